// File: rtl/booth_accumulator_if.sv
// Product-in / sum-out handshake bundle for booth_accumulator.
// The master side is the producer and consumer; the slave side is the accumulator.
interface booth_accumulator_if #(
  parameter int ACC_W = 12
);
  logic             clear;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_product;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [7:0]       out_count;
  logic             overflow;

  modport master (
    output clear, in_valid, in_product, out_ready,
    input  in_ready, out_valid, out_sum, out_count, overflow
  );

  modport slave (
    input  clear, in_valid, in_product, out_ready,
    output in_ready, out_valid, out_sum, out_count, overflow
  );
endinterface

// File: rtl/booth_accumulator.sv
// Sums NUM_TERMS signed 8-bit Booth products into an ACC_W-bit result and holds it until consumed.
// Optional macro BOOTH_ACC_SAT_EN: saturate on signed overflow instead of wrapping.
module booth_accumulator #(
  parameter int ACC_W     = 12,
  parameter int NUM_TERMS = 4
) (
  input  logic                clk,
  input  logic                reset,
  booth_accumulator_if.slave  bus
);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [7:0]       LAST_CNT = 8'(NUM_TERMS);
  localparam logic [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};

  state_t           r_state, w_state_nxt;
  logic [ACC_W-1:0] r_acc, w_acc_nxt;
  logic [7:0]       r_count, w_count_nxt, w_count_inc;
  logic             r_ovf, w_ovf_nxt;
  logic             r_run;
  logic [ACC_W-1:0] w_prod_ext, w_sum;
  logic             w_add_ovf, w_in_ready, w_xfer;

  function automatic logic signed_add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  assign w_prod_ext  = ACC_W'($signed(bus.in_product));
  assign w_sum       = r_acc + w_prod_ext;
  assign w_add_ovf   = signed_add_ovf(r_acc[ACC_W-1], w_prod_ext[ACC_W-1], w_sum[ACC_W-1]);
  assign w_count_inc = r_count + 8'd1;

  // r_run keeps in_ready low until the first edge after reset releases.
  assign w_in_ready = r_run && (r_state == ACCUM) && !bus.clear;
  assign w_xfer     = bus.in_valid && w_in_ready;

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state == HOLD);
  assign bus.out_sum   = r_acc;
  assign bus.out_count = r_count;
  assign bus.overflow  = r_ovf;

  // Next-state and datapath update; clear overrides transfers and handshakes.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_count_nxt = r_count;
    w_ovf_nxt   = r_ovf;
    if (bus.clear) begin
      w_state_nxt = ACCUM;
      w_acc_nxt   = '0;
      w_count_nxt = 8'd0;
      w_ovf_nxt   = 1'b0;
    end else begin
      case (r_state)
        ACCUM: begin
          if (w_xfer) begin
`ifdef BOOTH_ACC_SAT_EN
            if (w_add_ovf) begin
              w_acc_nxt = r_acc[ACC_W-1] ? ACC_MIN : ACC_MAX;
            end else begin
              w_acc_nxt = w_sum;
            end
`else
            w_acc_nxt = w_sum;
`endif
            w_count_nxt = w_count_inc;
            w_ovf_nxt   = r_ovf | w_add_ovf;
            if (w_count_inc == LAST_CNT) begin
              w_state_nxt = HOLD;
            end else begin
              w_state_nxt = ACCUM;
            end
          end else begin
            w_state_nxt = ACCUM;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            w_state_nxt = ACCUM;
            w_acc_nxt   = '0;
            w_count_nxt = 8'd0;
            w_ovf_nxt   = 1'b0;
          end else begin
            w_state_nxt = HOLD;
          end
        end
        default: begin
          w_state_nxt = ACCUM;
          w_acc_nxt   = '0;
          w_count_nxt = 8'd0;
          w_ovf_nxt   = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ACCUM;
      r_acc   <= '0;
      r_count <= 8'd0;
      r_ovf   <= 1'b0;
      r_run   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_count <= w_count_nxt;
      r_ovf   <= w_ovf_nxt;
      r_run   <= 1'b1;
    end
  end

endmodule

// File: doc/booth_accumulator.md
BOOTH_ACCUMULATOR -- requirements
Module: booth_accumulator

Interface
REQ-001 Parameter ACC_W, default 12, accumulator width in bits; legal range 8..32.
REQ-002 Parameter NUM_TERMS, default 4, products summed per result; legal range 1..255.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 clear  input  1  synchronous abort of the current sum.
REQ-006 in_valid  input  1  in_product holds a valid product.
REQ-007 in_ready  output  1  block accepts a product this cycle.
REQ-008 in_product  input  8  signed two's-complement product from the 4x4 Booth multiplier stage.
REQ-009 out_valid  output  1  out_sum holds a completed sum.
REQ-010 out_ready  input  1  consumer accepts out_sum.
REQ-011 out_sum  output  ACC_W  signed accumulated result.
REQ-012 out_count  output  8  products accepted in the current sum.
REQ-013 overflow  output  1  sticky signed-overflow flag for the current sum.

Function
REQ-014 The FSM SHALL have exactly two states: ACCUM and HOLD.
REQ-015 in_ready SHALL equal (state==ACCUM && !clear); out_valid SHALL equal (state==HOLD).
REQ-016 A transfer SHALL occur when in_valid && in_ready; the block SHALL then add sign-extended in_product to acc and increment out_count.
REQ-017 The block SHALL accept one product per cycle in ACCUM with no bubbles.
REQ-018 The transfer that makes out_count equal NUM_TERMS SHALL move the FSM to HOLD; out_valid SHALL rise the following cycle.
REQ-019 out_sum SHALL be driven continuously from acc; it is meaningful only while out_valid is high.
REQ-020 In HOLD, out_sum, out_count and overflow SHALL stay stable until out_valid && out_ready.
REQ-021 On out_valid && out_ready, acc, out_count and overflow SHALL clear, and the FSM SHALL enter ACCUM; in_ready SHALL be high the next cycle.
REQ-022 Signed overflow SHALL be detected when the operands of an addition have equal signs and the result sign differs; overflow SHALL then set and hold until the sum is consumed, cleared or reset.
REQ-023 clear SHALL take priority over every other event: acc, out_count and overflow go to 0, the FSM enters ACCUM, out_valid drops, and any same-cycle in_valid or out_ready is ignored.
REQ-024 With NUM_TERMS=1, every accepted product SHALL produce a result.

Reset
REQ-025 While reset is high, state SHALL be ACCUM, acc=0, out_count=0, overflow=0, out_valid=0 and in_ready=0.
REQ-026 in_ready SHALL rise on the first clk edge after reset deasserts.
REQ-027 Reset mid-sum or in HOLD SHALL discard all partial state with no output.

Configuration
REQ-028 Macro BOOTH_ACC_SAT_EN defined: an overflowing addition SHALL clamp acc to 2^(ACC_W-1)-1 (positive overflow) or -2^(ACC_W-1) (negative overflow); later additions proceed from the clamped value.
REQ-029 Macro BOOTH_ACC_SAT_EN undefined: additions SHALL wrap modulo 2^ACC_W; overflow SHALL still be reported.

Verification
REQ-030 Defaults; products 7, -8, 15, -1 on consecutive cycles -> out_valid one cycle after the 4th, out_sum=0x00D, out_count=4, overflow=0.
REQ-031 out_ready held low 5 cycles in HOLD; in_valid held high -> in_ready=0, out_sum/out_valid stable; first product accepted the cycle after the handshake.
REQ-032 ACC_W=8, NUM_TERMS=2; products 100, 100 -> overflow=1; out_sum=0xC8 without the macro, 0x7F with it.
REQ-033 ACC_W=8, NUM_TERMS=2; products -128, -128 -> overflow=1; out_sum=0x00 without the macro, 0x80 with it.
REQ-034 Two products accepted, then reset pulse, then 4 products of 1 -> out_sum=4, out_count=4.
REQ-035 clear asserted in HOLD together with out_ready -> out_valid=0 next cycle, acc=0, out_count=0, in_ready=1 once clear drops.
